pkt_wrr_sched: RTL

- Parametrised packet-level weighted round-robin scheduler for the downstream RX merge path.
- Selects which of IF_COUNT AXI-Stream inputs drives the shared output mux. The mux itself is external and is steered by sel/en.
- Holds each grant for a whole packet, never mid-packet.
- Grants up to a per-input weight of consecutive packets before rotating.
- Skips idle or masked inputs.

---
 rtl/pkt_wrr_sched_if.sv | 29 ++
 rtl/pkt_wrr_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_wrr_sched_if.sv
// Scheduler bundle: input observation, config, output handshake and grant.
// The master side drives stimulus and the slave side is the scheduler.
interface pkt_wrr_sched_if #(
    parameter int IF_COUNT     = 3,
    parameter int SEL_WIDTH    = $clog2(IF_COUNT),
    parameter int WEIGHT_WIDTH = 4
);
    logic [IF_COUNT-1:0]              s_axis_tvalid;
    logic [IF_COUNT*WEIGHT_WIDTH-1:0] cfg_weight;
    logic [IF_COUNT-1:0]              cfg_enable;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;
    logic                             m_axis_tlast;
    logic [SEL_WIDTH-1:0]             sel;
    logic                             en;
    logic                             in_packet;

    modport master (
        output s_axis_tvalid, cfg_weight, cfg_enable,
        output m_axis_tvalid, m_axis_tready, m_axis_tlast,
        input  sel, en, in_packet
    );

    modport slave (
        input  s_axis_tvalid, cfg_weight, cfg_enable,
        input  m_axis_tvalid, m_axis_tready, m_axis_tlast,
        output sel, en, in_packet
    );
endinterface

// File: rtl/pkt_wrr_sched.sv
// Packet-level weighted round-robin scheduler steering an external mux.
// Grants are held per packet; each input gets up to its weight in packets.
module pkt_wrr_sched #(
    parameter int IF_COUNT     = 3,
    parameter int SEL_WIDTH    = $clog2(IF_COUNT),
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pkt_wrr_sched_if.slave sched
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_PACKET = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(IF_COUNT - 1);

    state_t                  r_state;
    logic [SEL_WIDTH-1:0]    r_sel;
    logic                    r_en;
    logic                    r_in_pkt;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic [SEL_WIDTH-1:0]    r_last_ptr;

    state_t                  w_state_nxt;
    logic [SEL_WIDTH-1:0]    w_sel_nxt;
    logic                    w_en_nxt;
    logic                    w_in_pkt_nxt;
    logic [WEIGHT_WIDTH-1:0] w_credit_nxt;
    logic [SEL_WIDTH-1:0]    w_last_ptr_nxt;

    logic                    w_beat;
    logic [IF_COUNT-1:0]     w_req;
    logic                    w_sel_ok;
    logic                    w_req_sel;
    logic [SEL_WIDTH-1:0]    w_base;
    logic                    w_found;
    logic [SEL_WIDTH-1:0]    w_pick;
    logic [WEIGHT_WIDTH-1:0] w_pick_wt;
    logic [WEIGHT_WIDTH-1:0] w_cred_dec;
    logic                    w_end;
    logic                    w_rearb;

    // First requester after p, wrapping, ending with p itself; MSB = found.
    function automatic logic [SEL_WIDTH:0] pick(
        input logic [IF_COUNT-1:0]  req,
        input logic [SEL_WIDTH-1:0] p
    );
        logic                 found;
        logic [SEL_WIDTH-1:0] res;
        int                   idx;
        found = 1'b0;
        res   = '0;
        for (int k = 1; k <= IF_COUNT; k++) begin
            idx = (int'(p) + k) % IF_COUNT;
            if (!found && req[idx[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                res   = idx[SEL_WIDTH-1:0];
            end
        end
        return {found, res};
    endfunction

    // Quantum of one input; a zero weight still yields one packet.
    function automatic logic [WEIGHT_WIDTH-1:0] weight_of(
        input logic [IF_COUNT*WEIGHT_WIDTH-1:0] cfg,
        input logic [SEL_WIDTH-1:0]             idx
    );
        logic [WEIGHT_WIDTH-1:0] w;
        w = cfg[int'(idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        if (w == '0) begin
            w = WEIGHT_WIDTH'(1);
        end
        return w;
    endfunction

    // Arbitration inputs shared by every state.
    always_comb begin
        w_beat     = sched.m_axis_tvalid & sched.m_axis_tready & r_en;
        w_req      = sched.s_axis_tvalid & sched.cfg_enable;
        w_sel_ok   = int'(r_sel) < IF_COUNT;
        w_req_sel  = w_sel_ok ? w_req[r_sel] : 1'b0;
        w_base     = (r_state == S_IDLE) ? r_last_ptr : r_sel;
        {w_found, w_pick} = pick(w_req, w_base);
        w_pick_wt  = weight_of(sched.cfg_weight, w_pick);
        w_cred_dec = (r_credit != '0) ? r_credit - 1'b1 : '0;
    end

    // State and grant registers; reset may abort an open packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_en       <= 1'b0;
            r_in_pkt   <= 1'b0;
            r_credit   <= '0;
            r_last_ptr <= LAST_IDX;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_en       <= w_en_nxt;
            r_in_pkt   <= w_in_pkt_nxt;
            r_credit   <= w_credit_nxt;
            r_last_ptr <= w_last_ptr_nxt;
        end
    end

    // Next state: hold grant within a packet, rotate when credit runs out.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_en_nxt       = r_en;
        w_in_pkt_nxt   = r_in_pkt;
        w_credit_nxt   = r_credit;
        w_last_ptr_nxt = r_last_ptr;
        w_end          = 1'b0;
        w_rearb        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_en_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_sel_nxt    = w_pick;
                    w_en_nxt     = 1'b1;
                    w_credit_nxt = w_pick_wt;
                end
            end
            S_GRANT: begin
                if (w_beat && !sched.m_axis_tlast) begin
                    w_state_nxt  = S_PACKET;
                    w_in_pkt_nxt = 1'b1;
                end else if (w_beat) begin
                    w_end = 1'b1;
                end else if (!w_req_sel) begin
                    w_rearb = 1'b1;
                end
            end
            S_PACKET: begin
                if (w_beat && sched.m_axis_tlast) begin
                    w_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_end && w_cred_dec != '0 && w_req_sel) begin
            w_state_nxt  = S_GRANT;
            w_in_pkt_nxt = 1'b0;
            w_credit_nxt = w_cred_dec;
        end else if (w_end || w_rearb) begin
            w_in_pkt_nxt   = 1'b0;
            w_last_ptr_nxt = r_sel;
            if (w_found) begin
                w_state_nxt  = S_GRANT;
                w_sel_nxt    = w_pick;
                w_en_nxt     = 1'b1;
                w_credit_nxt = w_pick_wt;
            end else begin
                w_state_nxt  = S_IDLE;
                w_en_nxt     = 1'b0;
                w_credit_nxt = '0;
            end
        end

        if (!w_sel_ok) begin
            w_state_nxt  = S_IDLE;
            w_sel_nxt    = '0;
            w_en_nxt     = 1'b0;
            w_in_pkt_nxt = 1'b0;
            w_credit_nxt = '0;
        end
    end

    // Outputs come straight from registers so the mux sees no glitches.
    always_comb begin
        sched.sel       = r_sel;
        sched.en        = r_en;
        sched.in_packet = r_in_pkt;
    end
endmodule
